// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter_if
// Description : Requester/FIFO write-side bundle shared by the write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int GID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          full;
    logic                          winc;
    logic [DATA_WIDTH-1:0]         wdata;
    logic [GID_W-1:0]              grant_id;
    logic                          busy;
    logic [15:0]                   stall_cnt;

    modport master (
        output req_valid, req_data, req_last, full,
        input  req_ready, winc, wdata, grant_id, busy, stall_cnt
    );

    modport slave (
        input  req_valid, req_data, req_last, full,
        output req_ready, winc, wdata, grant_id, busy, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port, full-gated.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8
) (
    input  logic              wclk,
    input  logic              wrst_n,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state_q;
    logic [GID_W-1:0] grant_id_q;
    logic [GID_W-1:0] rr_ptr_q;
    logic             busy_q;
    logic [7:0]       beat_cnt_q;
    logic [15:0]      stall_cnt_q;

    logic [GID_W-1:0] w_pick;
    logic [GID_W-1:0] w_idx;
    logic [GID_W-1:0] w_rr_next;
    logic             w_owner_valid;
    logic             w_accept;
    logic             w_burst_end;
    logic             w_release;

    // Scan downward so the candidate closest to rr_ptr overwrites the others.
    always_comb begin
        w_pick = '0;
        w_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = GID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (bus.req_valid[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    assign w_owner_valid = bus.req_valid[grant_id_q];
    assign w_accept      = (state_q == LOCK) && w_owner_valid && !bus.full;
    assign w_burst_end   = (beat_cnt_q == 8'(MAX_BURST - 1));
    assign w_release     = !w_owner_valid
                         || (w_accept && (bus.req_last[grant_id_q] || w_burst_end));
    assign w_rr_next     = (grant_id_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        bus.req_ready = '0;
        bus.wdata     = '0;
        if (state_q == LOCK) begin
            bus.req_ready[grant_id_q] = !bus.full;
            bus.wdata = bus.req_data[grant_id_q * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.winc      = w_accept;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = busy_q;
    assign bus.stall_cnt = stall_cnt_q;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            busy_q      <= 1'b0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.req_valid) begin
                        grant_id_q <= w_pick;
                        busy_q     <= 1'b1;
                        beat_cnt_q <= '0;
                        state_q    <= LOCK;
                    end
                end
                LOCK: begin
                    if (w_owner_valid && bus.full && (stall_cnt_q != 16'hFFFF)) begin
                        stall_cnt_q <= stall_cnt_q + 16'd1;
                    end
                    if (w_accept) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                    end
                    // grant_id is left untouched on release so the last owner stays visible.
                    if (w_release) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= w_rr_next;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Scoreboard bench for the round-robin FIFO write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;
    logic clk;
    logic rst_n;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(8)) dut (
        .wclk   (clk),
        .wrst_n (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Producer model: words remaining, next word value, last-flag mode
    // (0 = never, 1 = on final word, 2 = on every word).
    int         rem   [4];
    logic [7:0] nxt   [4];
    int         lmode [4];

    logic [7:0] exp_d[$];
    logic [1:0] exp_g[$];
    logic [7:0] obs_d[$];
    logic [1:0] obs_g[$];

    logic        s_winc, s_busy;
    logic [1:0]  s_gid;
    logic [3:0]  s_ready;
    logic [7:0]  s_wdata;
    logic [15:0] s_stall;

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus.req_valid[i]        = (rem[i] > 0);
            bus.req_data[i*8 +: 8]  = nxt[i];
            bus.req_last[i]         = (rem[i] > 0) && ((lmode[i] == 2) || (lmode[i] == 1 && rem[i] == 1));
        end
    endtask

    task automatic load(input int r, input int n, input logic [7:0] base, input int lm);
        rem[r] = n; nxt[r] = base; lmode[r] = lm;
    endtask

    task automatic expect_run(input int r, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            exp_d.push_back(base + 8'(k));
            exp_g.push_back(2'(r));
        end
    endtask

    // Samples outputs at the falling edge, records writes, then advances the producers.
    task automatic tick();
        logic [3:0] hs;
        @(negedge clk);
        s_winc = bus.winc; s_busy = bus.busy; s_gid = bus.grant_id;
        s_ready = bus.req_ready; s_wdata = bus.wdata; s_stall = bus.stall_cnt;
        if (bus.winc) begin
            obs_d.push_back(bus.wdata);
            obs_g.push_back(bus.grant_id);
        end
        hs = bus.req_ready & bus.req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                rem[i]--;
                nxt[i]++;
            end
        end
        drive();
    endtask

    task automatic test_reset();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.winc !== 1'b0) begin failures++; $display("FAIL reset_winc got=%0b exp=0", bus.winc); end
        checks++; if (bus.req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
        checks++; if (bus.wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h exp=00", bus.wdata); end
        checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL reset_gid got=%0d exp=0", bus.grant_id); end
        checks++; if (bus.stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        load(2, 3, 8'h20, 1); drive();
        expect_run(2, 3, 8'h20);
        tick();
        checks++; if (s_winc !== 1'b0) begin failures++; $display("FAIL single_idle_winc got=%0b exp=0", s_winc); end
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%0b exp=0", s_busy); end
        tick();
        checks++; if (s_gid !== 2'd2) begin failures++; $display("FAIL single_gid got=%0d exp=2", s_gid); end
        checks++; if (s_busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%0b exp=1", s_busy); end
        checks++; if (s_winc !== 1'b1) begin failures++; $display("FAIL single_winc got=%0b exp=1", s_winc); end
        tick(); tick(); tick();
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL single_release_busy got=%0b exp=0", s_busy); end
        checks++;
        if (obs_d.size() != exp_d.size()) begin failures++; $display("FAIL single_count got=%0d exp=%0d", obs_d.size(), exp_d.size()); end
        while (exp_d.size() > 0 && obs_d.size() > 0) begin
            logic [7:0] ed, od; logic [1:0] eg, og;
            ed = exp_d.pop_front(); eg = exp_g.pop_front(); od = obs_d.pop_front(); og = obs_g.pop_front();
            checks++;
            if (od !== ed || og !== eg) begin failures++; $display("FAIL single_word got=%h/g%0d exp=%h/g%0d", od, og, ed, eg); end
        end
        exp_d.delete(); exp_g.delete(); obs_d.delete(); obs_g.delete();
    endtask

    task automatic test_rotation();
        int n;
        // Pointer was left at 3 by the previous owner (requester 2).
        for (int i = 0; i < 4; i++) load(i, 2, 8'h30 + 8'(i * 16), 2);
        drive();
        for (int rnd = 0; rnd < 2; rnd++) begin
            exp_d.push_back(8'h60 + 8'(rnd)); exp_g.push_back(2'd3);
            for (int i = 0; i < 3; i++) begin
                exp_d.push_back(8'h30 + 8'(i * 16) + 8'(rnd)); exp_g.push_back(2'(i));
            end
        end
        n = 0;
        while (obs_d.size() < 8 && n < 40) begin tick(); n++; end
        checks++; if (n != 16) begin failures++; $display("FAIL rotation_cycles got=%0d exp=16", n); end
        checks++;
        if (obs_d.size() != exp_d.size()) begin failures++; $display("FAIL rotation_count got=%0d exp=%0d", obs_d.size(), exp_d.size()); end
        while (exp_d.size() > 0 && obs_d.size() > 0) begin
            logic [7:0] ed, od; logic [1:0] eg, og;
            ed = exp_d.pop_front(); eg = exp_g.pop_front(); od = obs_d.pop_front(); og = obs_g.pop_front();
            checks++;
            if (od !== ed || og !== eg) begin failures++; $display("FAIL rotation_word got=%h/g%0d exp=%h/g%0d", od, og, ed, eg); end
        end
        exp_d.delete(); exp_g.delete(); obs_d.delete(); obs_g.delete();
    endtask

    task automatic test_burst_cap();
        int n;
        load(1, 20, 8'h40, 0); load(2, 2, 8'h60, 1); drive();
        expect_run(1, 8, 8'h40);
        expect_run(2, 2, 8'h60);
        expect_run(1, 8, 8'h48);
        expect_run(1, 4, 8'h50);
        n = 0;
        while (obs_d.size() < 22 && n < 200) begin tick(); n++; end
        tick(); tick();
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL burst_final_busy got=%0b exp=0", s_busy); end
        checks++;
        if (obs_d.size() != exp_d.size()) begin failures++; $display("FAIL burst_count got=%0d exp=%0d", obs_d.size(), exp_d.size()); end
        while (exp_d.size() > 0 && obs_d.size() > 0) begin
            logic [7:0] ed, od; logic [1:0] eg, og;
            ed = exp_d.pop_front(); eg = exp_g.pop_front(); od = obs_d.pop_front(); og = obs_g.pop_front();
            checks++;
            if (od !== ed || og !== eg) begin failures++; $display("FAIL burst_word got=%h/g%0d exp=%h/g%0d", od, og, ed, eg); end
        end
        exp_d.delete(); exp_g.delete(); obs_d.delete(); obs_g.delete();
    endtask

    task automatic test_full_stall();
        int n;
        load(3, 6, 8'h80, 1); drive();
        expect_run(3, 6, 8'h80);
        tick(); tick(); tick();
        bus.full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (s_winc !== 1'b0 || s_ready !== 4'b0 || s_busy !== 1'b1 || s_gid !== 2'd3) begin
                failures++;
                $display("FAIL stall_hold c=%0d got winc=%0b ready=%b busy=%0b gid=%0d exp 0/0000/1/3", c, s_winc, s_ready, s_busy, s_gid);
            end
        end
        bus.full = 1'b0;
        tick();
        checks++; if (s_stall !== 16'd5) begin failures++; $display("FAIL stall_cnt got=%0d exp=5", s_stall); end
        checks++; if (s_winc !== 1'b1) begin failures++; $display("FAIL stall_resume got=%0b exp=1", s_winc); end
        n = 0;
        while (obs_d.size() < 6 && n < 20) begin tick(); n++; end
        tick();
        checks++;
        if (obs_d.size() != exp_d.size()) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", obs_d.size(), exp_d.size()); end
        while (exp_d.size() > 0 && obs_d.size() > 0) begin
            logic [7:0] ed, od; logic [1:0] eg, og;
            ed = exp_d.pop_front(); eg = exp_g.pop_front(); od = obs_d.pop_front(); og = obs_g.pop_front();
            checks++;
            if (od !== ed || og !== eg) begin failures++; $display("FAIL stall_word got=%h/g%0d exp=%h/g%0d", od, og, ed, eg); end
        end
        exp_d.delete(); exp_g.delete(); obs_d.delete(); obs_g.delete();
    endtask

    task automatic test_owner_drop();
        load(0, 10, 8'hA0, 0); load(3, 1, 8'hB0, 1); drive();
        expect_run(0, 3, 8'hA0);
        expect_run(3, 1, 8'hB0);
        tick(); tick(); tick(); tick();
        rem[0] = 0; drive();
        tick();
        checks++; if (s_winc !== 1'b0 || s_busy !== 1'b1) begin failures++; $display("FAIL drop_lock got winc=%0b busy=%0b exp 0/1", s_winc, s_busy); end
        tick();
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL drop_idle_busy got=%0b exp=0", s_busy); end
        tick();
        checks++; if (s_gid !== 2'd3 || s_winc !== 1'b1 || s_wdata !== 8'hB0) begin failures++; $display("FAIL drop_regrant got gid=%0d winc=%0b wdata=%h exp 3/1/b0", s_gid, s_winc, s_wdata); end
        tick();
        checks++;
        if (obs_d.size() != exp_d.size()) begin failures++; $display("FAIL drop_count got=%0d exp=%0d", obs_d.size(), exp_d.size()); end
        while (exp_d.size() > 0 && obs_d.size() > 0) begin
            logic [7:0] ed, od; logic [1:0] eg, og;
            ed = exp_d.pop_front(); eg = exp_g.pop_front(); od = obs_d.pop_front(); og = obs_g.pop_front();
            checks++;
            if (od !== ed || og !== eg) begin failures++; $display("FAIL drop_word got=%h/g%0d exp=%h/g%0d", od, og, ed, eg); end
        end
        exp_d.delete(); exp_g.delete(); obs_d.delete(); obs_g.delete();
    endtask

    task automatic test_reset_mid();
        int n;
        load(1, 10, 8'hC8, 0); drive();
        tick(); tick();
        bus.full = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.winc !== 1'b0) begin failures++; $display("FAIL rstmid_winc got=%0b exp=0", bus.winc); end
        checks++; if (bus.req_ready !== 4'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0000", bus.req_ready); end
        checks++; if (bus.stall_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_stall got=%0d exp=0", bus.stall_cnt); end
        bus.full = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        obs_d.delete(); obs_g.delete();
        load(0, 1, 8'hC0, 1); drive();
        expect_run(0, 1, 8'hC0);
        n = 0;
        while (obs_d.size() < 1 && n < 20) begin tick(); n++; end
        checks++;
        if (obs_d.size() < 1) begin
            failures++; $display("FAIL rstmid_restart got=none exp=g0/c0");
        end else if (obs_g[0] !== exp_g[0] || obs_d[0] !== exp_d[0]) begin
            failures++; $display("FAIL rstmid_restart got=g%0d/%h exp=g%0d/%h", obs_g[0], obs_d[0], exp_g[0], exp_d[0]);
        end
        for (int i = 0; i < 4; i++) rem[i] = 0;
        drive();
        tick(); tick(); tick();
        exp_d.delete(); exp_g.delete(); obs_d.delete(); obs_g.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        bus.full = 1'b0;
        for (int i = 0; i < 4; i++) begin rem[i] = 0; nxt[i] = 8'h00; lmode[i] = 0; end
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        test_reset();
        test_single();
        test_rotation();
        test_burst_cap();
        test_full_stall();
        test_owner_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
